// File: rtl/mul_pkg.sv
// Shared encodings and the captured-request record for the multiply sequencer.
package mul_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_MADD = 2'b10;
    localparam logic [1:0] OP_MSUB = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] hi;
        logic [31:0] lo;
    } mul_req_t;

    // MUL is the only op that retires to the GPR file instead of HI/LO.
    function automatic logic writes_gpr(input logic [1:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/mul_accum_unit.sv
// Combinational 64-bit signed multiply, optionally accumulated into {Hi,Lo}.
module mul_accum_unit
    import mul_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic signed [63:0] w_a_ext;
    logic signed [63:0] w_b_ext;
    logic        [63:0] w_prod;
    logic        [63:0] w_acc;
    logic        [63:0] w_res;

    assign w_a_ext = {{32{i_a[31]}}, i_a};
    assign w_b_ext = {{32{i_b[31]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_acc   = {i_hi, i_lo};

    // Select plain product or wrap-around accumulate/subtract.
    always_comb begin
        w_res = w_prod;
        case (i_op)
            OP_MUL:  w_res = w_prod;
            OP_MULT: w_res = w_prod;
            OP_MADD: w_res = w_acc + w_prod;
            OP_MSUB: w_res = w_acc - w_prod;
            default: w_res = w_prod;
        endcase
    end

    assign o_hi = w_res[63:32];
    assign o_lo = w_res[31:0];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MULT/MADD/MSUB sequencer: stalls the pipeline front for
// LATENCY cycles, then retires the result to HI/LO or a GPR.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned LATENCY = 4
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  Rd,
    input  logic [31:0] HiIn,
    input  logic [31:0] LoIn,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        HiLoWrite,
    output logic        RegWriteMul,
    output logic [4:0]  RdOut
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 32'd1);
    localparam logic       LAT_ONE  = (LATENCY == 32'd1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    mul_req_t    r_req;
    mul_req_t    w_req_in;
    mul_req_t    w_req_sel;
    logic        w_start_ok;
    logic        w_finish;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        r_done;
    logic        r_hilo_we;
    logic        r_reg_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_rd;

    assign w_start_ok = Start & (r_state != ST_RUN);
    assign w_req_in   = '{op: Op, a: A, b: B, rd: Rd, hi: HiIn, lo: LoIn};
    // With LATENCY=1 the result retires straight from the live operands.
    assign w_req_sel  = (r_state == ST_RUN) ? r_req : w_req_in;
    assign w_finish   = ((r_state == ST_RUN) && (r_cnt <= 4'd1)) || (w_start_ok && LAT_ONE);

    mul_accum_unit u_accum (
        .i_op (w_req_sel.op),
        .i_a  (w_req_sel.a),
        .i_b  (w_req_sel.b),
        .i_hi (w_req_sel.hi),
        .i_lo (w_req_sel.lo),
        .o_hi (w_hi),
        .o_lo (w_lo)
    );

    // Next-state and counter; the counter hits zero as RUN hands over to DONE.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok && LAT_ONE) begin
                    w_state_nxt = ST_DONE;
                end else if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, capture and registered retirement outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_req     <= '0;
            r_done    <= 1'b0;
            r_hilo_we <= 1'b0;
            r_reg_we  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_rd      <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_finish;
            r_hilo_we <= w_finish & ~writes_gpr(w_req_sel.op);
            r_reg_we  <= w_finish & writes_gpr(w_req_sel.op);
            if (w_start_ok) begin
                r_req <= w_req_in;
            end
            if (w_finish) begin
                r_hi <= w_hi;
                r_lo <= w_lo;
                r_rd <= w_req_sel.rd;
            end
        end
    end

    assign Busy        = (r_state == ST_RUN) | w_start_ok;
    assign Done        = r_done;
    assign HiLoWrite   = r_hilo_we;
    assign RegWriteMul = r_reg_we;
    assign HiOut       = r_hi;
    assign LoOut       = r_lo;
    assign RdOut       = r_rd;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed-vector bench for mul_sequencer at LATENCY=4 and LATENCY=1.
module tb_mul_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        s4, s1;
    logic [1:0]  Op;
    logic [31:0] A, B, HiIn, LoIn;
    logic [4:0]  Rd;

    logic        b4, d4, hw4, rw4, b1, d1, hw1, rw1;
    logic [31:0] h4, l4, h1, l1;
    logic [4:0]  rd4, rd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    mul_sequencer #(.LATENCY(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(s4), .Op(Op), .A(A), .B(B), .Rd(Rd),
        .HiIn(HiIn), .LoIn(LoIn), .Busy(b4), .Done(d4), .HiOut(h4), .LoOut(l4),
        .HiLoWrite(hw4), .RegWriteMul(rw4), .RdOut(rd4)
    );

    mul_sequencer #(.LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(s1), .Op(Op), .A(A), .B(B), .Rd(Rd),
        .HiIn(HiIn), .LoIn(LoIn), .Busy(b1), .Done(d1), .HiOut(h1), .LoOut(l1),
        .HiLoWrite(hw1), .RegWriteMul(rw1), .RdOut(rd1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ops(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] hi, input logic [31:0] lo);
        Op = op; A = a; B = b; Rd = rd; HiIn = hi; LoIn = lo;
    endtask

    // Start on dut4 at cycle t, scramble inputs after capture, check Busy t..t+3 and retire at t+4.
    task automatic run4(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_hw, input logic exp_rw);
        set_ops(op, a, b, rd, hi, lo);
        s4 = 1'b1;
        #1 check_eq({tag, ".busy_t"}, 64'(b4), 64'd1);
        tick();
        s4 = 1'b0;
        set_ops(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 32'h5555_5555, 32'hAAAA_AAAA);
        for (int i = 1; i < 4; i++) begin
            #1 check_eq($sformatf("%s.busy_t%0d", tag, i), 64'(b4), 64'd1);
            check_eq($sformatf("%s.nodone_t%0d", tag, i), 64'(d4), 64'd0);
            tick();
        end
        #1;
        check_eq({tag, ".busy_t4"}, 64'(b4), 64'd0);
        check_eq({tag, ".done"}, 64'(d4), 64'd1);
        check_eq({tag, ".hilo_we"}, 64'(hw4), 64'(exp_hw));
        check_eq({tag, ".reg_we"}, 64'(rw4), 64'(exp_rw));
        check_eq({tag, ".hilo"}, {h4, l4}, {exp_hi, exp_lo});
        if (exp_rw) check_eq({tag, ".rd"}, 64'(rd4), 64'(rd));
        tick();
        #1;
        check_eq({tag, ".done_low"}, 64'(d4), 64'd0);
        check_eq({tag, ".we_low"}, 64'({hw4, rw4}), 64'd0);
        check_eq({tag, ".hold"}, {h4, l4}, {exp_hi, exp_lo});
    endtask

    initial begin
        Reset = 1'b1; s4 = 1'b0; s1 = 1'b0;
        set_ops(2'b00, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick(); tick();
        Reset = 1'b0;
        #1;
        check_eq("rst.ctl4", 64'({b4, d4, hw4, rw4}), 64'd0);
        check_eq("rst.data4", {h4, l4}, 64'd0);
        check_eq("rst.rd4", 64'(rd4), 64'd0);
        check_eq("rst.ctl1", 64'({b1, d1, hw1, rw1}), 64'd0);
        tick();

        run4("mult", 2'b01, 32'hFFFF_FFFD, 32'd7, 5'd3, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
        run4("madd", 2'b10, 32'd1, 32'd1, 5'd0, 32'd0, 32'hFFFF_FFFF,
             32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        run4("mul", 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h7777_7777, 32'h8888_8888,
             32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
        run4("msub4", 2'b11, 32'd3, 32'd4, 5'd0, 32'd0, 32'd10,
             32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // Back-to-back: second Start lands in the first DONE cycle.
        set_ops(2'b01, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'd0, 32'd0);
        s4 = 1'b1;
        #1 check_eq("b2b.busy_t0", 64'(b4), 64'd1);
        tick();
        s4 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1 check_eq($sformatf("b2b.busy_t%0d", i), 64'(b4), 64'd1);
            tick();
        end
        set_ops(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'd0, 32'd0);
        s4 = 1'b1;
        #1;
        check_eq("b2b.busy_t4", 64'(b4), 64'd1);
        check_eq("b2b.done1", 64'(d4), 64'd1);
        check_eq("b2b.res1", {h4, l4}, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        s4 = 1'b0;
        for (int i = 5; i < 8; i++) begin
            #1 check_eq($sformatf("b2b.busy_t%0d", i), 64'(b4), 64'd1);
            check_eq($sformatf("b2b.nodone_t%0d", i), 64'(d4), 64'd0);
            tick();
        end
        #1;
        check_eq("b2b.done2", 64'(d4), 64'd1);
        check_eq("b2b.we2", 64'({hw4, rw4}), 64'd1);
        check_eq("b2b.res2", {h4, l4}, 64'h0000_0001_0000_0000);
        check_eq("b2b.rd2", 64'(rd4), 64'd9);
        tick();

        // Reset two cycles into RUN: result discarded, outputs back to reset values.
        set_ops(2'b01, 32'd5, 32'd5, 5'd4, 32'd0, 32'd0);
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 3; i < 7; i++) begin
            #1 check_eq($sformatf("rstrun.ctl_t%0d", i), 64'({b4, d4, hw4, rw4}), 64'd0);
            check_eq($sformatf("rstrun.data_t%0d", i), {h4, l4}, 64'd0);
            tick();
        end

        // Reset wins over a simultaneous Start.
        s4 = 1'b1;
        Reset = 1'b1;
        tick();
        s4 = 1'b0;
        Reset = 1'b0;
        for (int i = 1; i < 6; i++) begin
            #1 check_eq($sformatf("rststart.ctl_t%0d", i), 64'({b4, d4, hw4, rw4}), 64'd0);
            tick();
        end

        // LATENCY=1 MSUB, followed immediately by a MULT started in its DONE cycle.
        set_ops(2'b11, 32'd3, 32'd4, 5'd0, 32'd0, 32'd10);
        s1 = 1'b1;
        #1 check_eq("lat1.busy_t", 64'(b1), 64'd1);
        tick();
        set_ops(2'b01, 32'd2, 32'd3, 5'd0, 32'd0, 32'd0);
        s1 = 1'b1;
        #1;
        check_eq("lat1.done", 64'(d1), 64'd1);
        check_eq("lat1.hilo_we", 64'({hw1, rw1}), 64'd2);
        check_eq("lat1.res", {h1, l1}, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("lat1.b2b_busy", 64'(b1), 64'd1);
        tick();
        s1 = 1'b0;
        #1;
        check_eq("lat1.busy_idle", 64'(b1), 64'd0);
        check_eq("lat1.done2", 64'(d1), 64'd1);
        check_eq("lat1.res2", {h1, l1}, 64'd6);
        tick();
        #1 check_eq("lat1.done_low", 64'(d1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
